// File: rtl/stack_pkg.sv
// stack_pkg: delta encodings and default depth shared by stack guards
package stack_pkg;
  localparam logic [1:0] DELTA_NONE = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;
  localparam int STACK_DEPTH = 18;
endpackage

// File: rtl/stack_hwm.sv
// stack_hwm: high-water mark of stack occupancy since reset
module stack_hwm #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] depth,
  output logic [DW-1:0] hwm
);
  always_ff @(posedge clk)
    hwm <= reset ? '0 : (depth > hwm ? depth : hwm);
endmodule

// File: rtl/stack_guard.sv
// stack_guard: occupancy tracking and over/underflow blocking for one J1 stack
// optional high-water mark under STACK_GUARD_HWM_EN
module stack_guard import stack_pkg::*; #(
  parameter int DEPTH = STACK_DEPTH,
  parameter int DW    = $clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [1:0]    delta,
  output logic          s_we,
  output logic [1:0]    s_delta,
  input  logic          err_clr,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          udf,
`ifdef STACK_GUARD_HWM_EN
  output logic [DW-1:0] hwm,
`endif
  output logic          err_pulse
);
  logic push, pop, blk_push, blk_pop;
  always_comb begin
    push     = delta == DELTA_PUSH;
    pop      = delta == DELTA_POP;
    empty    = depth == '0;
    full     = depth == DW'(DEPTH + 1);
    blk_push = push & full;
    blk_pop  = pop & empty;
    s_we     = we;
    s_delta  = (blk_push | blk_pop) ? DELTA_NONE : delta;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      depth     <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      depth     <= (push & ~full) ? depth + 1'b1 : (pop & ~empty) ? depth - 1'b1 : depth;
      ovf       <= blk_push | (ovf & ~err_clr);
      udf       <= blk_pop | (udf & ~err_clr);
      err_pulse <= blk_push | blk_pop;
    end
  end
`ifdef STACK_GUARD_HWM_EN
  stack_hwm #(.DW(DW)) u_hwm (.clk(clk), .reset(reset), .depth(depth), .hwm(hwm));
`endif
endmodule

// File: tb/tb_stack_guard.sv
// tb_stack_guard: directed checks of stack_guard blocking, flags and occupancy
module tb_stack_guard;
  localparam int DW = 5;
  logic clk = 0, reset = 1, we = 0, err_clr = 0;
  logic [1:0] delta = 2'b00, s_delta;
  logic s_we, empty, full, ovf, udf, err_pulse;
  logic [DW-1:0] depth;
`ifdef STACK_GUARD_HWM_EN
  logic [DW-1:0] hwm;
`endif
  int checks = 0, errors = 0;

  stack_guard #(.DEPTH(18)) dut (
    .clk(clk), .reset(reset), .we(we), .delta(delta), .s_we(s_we), .s_delta(s_delta),
    .err_clr(err_clr), .depth(depth), .empty(empty), .full(full), .ovf(ovf), .udf(udf),
`ifdef STACK_GUARD_HWM_EN
    .hwm(hwm),
`endif
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // apply one request, check the combinational path, then advance one clock
  task automatic go(input logic w, input logic [1:0] d, input logic c, input logic [1:0] exp_sd);
    we = w; delta = d; err_clr = c;
    #1;
    chk("s_we", 8'(s_we), 8'(w));
    chk("s_delta", 8'(s_delta), 8'(exp_sd));
    @(posedge clk); #1;
  endtask

  task automatic status(input string tag, input int d, input logic e, input logic f,
                        input logic o, input logic u, input logic p);
    chk({tag, " depth"}, 8'(depth), 8'(d));
    chk({tag, " empty"}, 8'(empty), 8'(e));
    chk({tag, " full"}, 8'(full), 8'(f));
    chk({tag, " ovf"}, 8'(ovf), 8'(o));
    chk({tag, " udf"}, 8'(udf), 8'(u));
    chk({tag, " err_pulse"}, 8'(err_pulse), 8'(p));
  endtask

  initial begin
    @(posedge clk); #1;
    go(1, 2'b01, 0, 2'b01);
    status("reset", 0, 1, 0, 0, 0, 0);
    reset = 0;
    go(1, 2'b11, 0, 2'b00);
    status("pop_empty", 0, 1, 0, 0, 1, 1);
    go(0, 2'b00, 0, 2'b00);
    status("after_udf", 0, 1, 0, 0, 1, 0);
    go(0, 2'b00, 1, 2'b00);
    status("udf_clr", 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) begin
      go(0, 2'b01, 0, 2'b01);
      chk("push_depth", 8'(depth), 8'(i));
    end
    status("full", 19, 0, 1, 0, 0, 0);
    go(1, 2'b01, 0, 2'b00);
    status("push_full", 19, 0, 1, 1, 0, 1);
    go(0, 2'b01, 0, 2'b00);
    status("push_full2", 19, 0, 1, 1, 0, 1);
    go(0, 2'b00, 0, 2'b00);
    status("after_ovf", 19, 0, 1, 1, 0, 0);
    go(0, 2'b00, 1, 2'b00);
    status("ovf_clr", 19, 0, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++) go(0, 2'b11, 0, 2'b11);
    status("pop14", 5, 0, 0, 0, 0, 0);
    go(1, 2'b00, 0, 2'b00);
    status("we_none", 5, 0, 0, 0, 0, 0);
    go(1, 2'b10, 0, 2'b10);
    status("we_10", 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) go(0, 2'b11, 0, 2'b11);
    status("drain", 0, 1, 0, 0, 0, 0);
    go(1, 2'b00, 0, 2'b00);
    status("we_empty", 0, 1, 0, 0, 0, 0);
    go(0, 2'b11, 1, 2'b00);
    status("clr_vs_pop", 0, 1, 0, 0, 1, 1);
    go(0, 2'b00, 1, 2'b00);
    for (int i = 0; i < 3; i++) go(0, 2'b01, 0, 2'b01);
    chk("pre_reset depth", 8'(depth), 8'd3);
    reset = 1;
    go(0, 2'b01, 0, 2'b01);
    status("mid_reset", 0, 1, 0, 0, 0, 0);
    reset = 0;
`ifdef STACK_GUARD_HWM_EN
    for (int i = 0; i < 7; i++) go(0, 2'b01, 0, 2'b01);
    for (int i = 0; i < 4; i++) go(0, 2'b11, 0, 2'b11);
    for (int i = 0; i < 2; i++) go(0, 2'b01, 0, 2'b01);
    go(0, 2'b00, 1, 2'b00);
    chk("hwm depth", 8'(depth), 8'd5);
    chk("hwm", 8'(hwm), 8'd7);
    reset = 1;
    go(0, 2'b00, 0, 2'b00);
    chk("hwm reset depth", 8'(depth), 8'd0);
    chk("hwm reset", 8'(hwm), 8'd0);
    reset = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
